video_mode_ctrl: RTL and testbench
==================================

Name: video_mode_ctrl

Overview:
Sequences video-mode changes for the VGA video core inside system.
- Holds the video core in reset until the PLL has been stably locked.
- Debounces the raw key_mode pushbutton and cycles through NUM_MODES modes.
- Applies each mode change glitch-free: blank on a frame boundary, handshake the new mode to the video core, unblank on a later frame boundary.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles key level must be stable before accepted (10 ms at 50 MHz)
NUM_MODES, 4, number of selectable modes; legal range 2..2**MODE_W
MODE_W, 2, width of mode index
BLANK_FRAMES, 2, frame_start pulses counted in BLANK before requesting the change (>=1)
LOCK_CYCLES, 32, consecutive pll_locked-high cycles required before video_reset release

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
pll_locked  in  1  PLL lock indicator; asynchronous, used after internal 2-flop sync
key_mode  in  1  raw pushbutton, active-low; asynchronous, used after internal 2-flop sync
frame_start  in  1  single-cycle pulse at start of vertical blank, from video core
mode_ack  in  1  video core accepted mode
mode  out  MODE_W  current or requested mode index to video core
mode_req  out  1  mode change request, level until acked
blank  out  1  force video output black
video_reset  out  1  active-high reset to video core
busy  out  1  mode change or reset hold in progress

Behaviour:
Reset values:
- mode=0, mode_req=0, blank=1, video_reset=1, busy=1.
- State=HOLD, lock counter=0, debounce counter=0, debounced key=1 (released).

Debounce:
- Synced key differing from the debounced value increments the counter; equality clears it.
- When the counter reaches DEBOUNCE_CYCLES-1, the debounced value flips.
- A 1->0 flip is a press: one-cycle internal pulse.
- Presses outside IDLE are dropped, not queued.

FSM:
- HOLD
  - video_reset=1, blank=1, busy=1.
  - Counts consecutive synced pll_locked=1 cycles; any 0 clears the count.
  - At count LOCK_CYCLES-1 -> IDLE; video_reset, blank, busy go 0 on that transition.
- IDLE
  - On press: next = (mode==NUM_MODES-1) ? 0 : mode+1, stored internally; busy=1; -> WAIT_VS1.
- WAIT_VS1
  - On frame_start: blank=1, frame counter=0; -> BLANK.
- BLANK
  - Each frame_start increments the frame counter.
  - When the counter reaches BLANK_FRAMES: mode<=next, mode_req=1 in the same cycle; -> REQ.
  - mode does not change before this point.
- REQ
  - mode_req held at 1 and mode held stable until mode_ack is sampled 1.
  - On that edge mode_req<=0 -> WAIT_VS2; mode_ack during the same cycle mode_req rises counts.
  - No timeout.
- WAIT_VS2
  - On frame_start: blank<=0, busy<=0; -> IDLE.
  - frame_start coincident with the REQ->WAIT_VS2 transition is not counted.

Global rules:
- Synced pll_locked=0 in any state -> HOLD next cycle, with video_reset=1, blank=1, busy=1, mode_req=0.
- mode keeps its value through HOLD; a pending next is discarded.
- Synchronous reset mid-sequence returns every register to its reset value in one cycle.
- Simultaneous press and pll_locked drop: the drop wins.

Optional Feature:
Macro VIDEO_MODE_DIRECT_SEL_EN adds input ports mode_sel (MODE_W) and mode_sel_valid (1) for CPU-driven selection.
- Enabled:
  - mode_sel_valid=1 in IDLE with mode_sel<NUM_MODES and mode_sel!=mode starts the same sequence with next=mode_sel.
  - Out-of-range or equal values are ignored.
  - Same-cycle press and mode_sel_valid: mode_sel wins.
- Disabled: ports absent; only key presses change mode.

Test Plan:
1. Bench DEBOUNCE_CYCLES=8, LOCK_CYCLES=32. Assert reset, raise pll_locked -> video_reset=1 for sync latency + 32 cycles, then video_reset=0, blank=0, busy=0, mode=0.
2. Pulse key_mode low for 5 cycles (bounce) then release -> no state change, mode stays 0. Hold low for 20 cycles -> busy=1.
3. Full sequence, BLANK_FRAMES=2:
   - press, frame_start, frame_start, frame_start -> blank rises on the first frame_start.
   - mode_req rises with mode=1 on the third.
   - mode_ack after 4 cycles -> mode_req drops the next cycle.
   - next frame_start -> blank=0, busy=0.
4. Wrap-around: from mode=3 with NUM_MODES=4, press and complete the sequence -> mode=0.
5. Drop pll_locked while in REQ -> within sync latency + 1 cycle: video_reset=1, mode_req=0, blank=1, mode unchanged. Relock for 32 cycles -> IDLE.
6. Press during BLANK -> ignored; exactly one mode increment after completion. With VIDEO_MODE_DIRECT_SEL_EN, mode_sel=2 with mode_sel_valid -> sequence ends with mode=2.

Source files
------------

// File: rtl/video_mode_ctrl_if.sv
// Video-core side of the mode controller: mode handshake, frame timing, blanking and core reset.
interface video_mode_ctrl_if #(
    parameter int unsigned MODE_W = 2
) ();
    logic [MODE_W-1:0] mode;
    logic              mode_req;
    logic              mode_ack;
    logic              frame_start;
    logic              blank;
    logic              video_reset;
    logic              busy;

    modport master (
        output mode, mode_req, blank, video_reset, busy,
        input  mode_ack, frame_start
    );

    modport slave (
        input  mode, mode_req, blank, video_reset, busy,
        output mode_ack, frame_start
    );
endinterface

// File: rtl/video_mode_ctrl.sv
// Video mode sequencer: PLL-lock reset hold, key debounce, glitch-free frame-aligned mode change.
// Optional CPU mode select ports enabled by `define VIDEO_MODE_DIRECT_SEL_EN.
module video_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned NUM_MODES       = 4,
    parameter int unsigned MODE_W          = 2,
    parameter int unsigned BLANK_FRAMES    = 2,
    parameter int unsigned LOCK_CYCLES     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pll_locked,
    input  logic              key_mode,
    video_mode_ctrl_if.master vif
`ifdef VIDEO_MODE_DIRECT_SEL_EN
    ,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              mode_sel_valid
`endif
);
    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned LKW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int unsigned FCW = $clog2(BLANK_FRAMES + 1);

    localparam logic [DBW-1:0]    DB_LAST      = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LKW-1:0]    LOCK_LAST    = LKW'(LOCK_CYCLES - 1);
    localparam logic [FCW-1:0]    FRAME_TARGET = FCW'(BLANK_FRAMES);
    localparam logic [MODE_W-1:0] MODE_LAST    = MODE_W'(NUM_MODES - 1);

    typedef enum logic [2:0] {
        HOLD, IDLE, WAIT_VS1, BLANK, REQ, WAIT_VS2
    } state_t;

    state_t            state_q;
    logic              pll_s1_q, pll_s2_q;
    logic              key_s1_q, key_s2_q, key_db_q;
    logic [DBW-1:0]    db_cnt_q;
    logic [LKW-1:0]    lock_cnt_q;
    logic [FCW-1:0]    frame_cnt_q;
    logic [MODE_W-1:0] next_q, mode_q;
    logic              mode_req_q, blank_q, video_reset_q, busy_q;

    logic              press_d;
    logic              start_d;
    logic [MODE_W-1:0] next_d;
    logic [FCW-1:0]    frame_inc_d;

    always_comb begin
        press_d     = (key_s2_q != key_db_q) && (db_cnt_q == DB_LAST) && key_db_q;
        start_d     = press_d;
        next_d      = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
        frame_inc_d = frame_cnt_q + FCW'(1);
`ifdef VIDEO_MODE_DIRECT_SEL_EN
        // A valid CPU selection overrides a simultaneous key press.
        if (mode_sel_valid && ({1'b0, mode_sel} < (MODE_W+1)'(NUM_MODES)) && (mode_sel != mode_q)) begin
            start_d = 1'b1;
            next_d  = mode_sel;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HOLD;
            pll_s1_q      <= 1'b0;
            pll_s2_q      <= 1'b0;
            key_s1_q      <= 1'b1;
            key_s2_q      <= 1'b1;
            key_db_q      <= 1'b1;
            db_cnt_q      <= '0;
            lock_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            next_q        <= '0;
            mode_q        <= '0;
            mode_req_q    <= 1'b0;
            blank_q       <= 1'b1;
            video_reset_q <= 1'b1;
            busy_q        <= 1'b1;
        end else begin
            pll_s1_q <= pll_locked;
            pll_s2_q <= pll_s1_q;
            key_s1_q <= key_mode;
            key_s2_q <= key_s1_q;

            if (key_s2_q != key_db_q) begin
                if (db_cnt_q == DB_LAST) begin
                    key_db_q <= key_s2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DBW'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end

            // Lock loss overrides every state, including a same-cycle press.
            if (!pll_s2_q) begin
                state_q       <= HOLD;
                lock_cnt_q    <= '0;
                mode_req_q    <= 1'b0;
                blank_q       <= 1'b1;
                video_reset_q <= 1'b1;
                busy_q        <= 1'b1;
            end else begin
                case (state_q)
                    HOLD: begin
                        if (lock_cnt_q == LOCK_LAST) begin
                            state_q       <= IDLE;
                            lock_cnt_q    <= '0;
                            video_reset_q <= 1'b0;
                            blank_q       <= 1'b0;
                            busy_q        <= 1'b0;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + LKW'(1);
                        end
                    end
                    IDLE: begin
                        if (start_d) begin
                            next_q  <= next_d;
                            busy_q  <= 1'b1;
                            state_q <= WAIT_VS1;
                        end
                    end
                    WAIT_VS1: begin
                        if (vif.frame_start) begin
                            blank_q     <= 1'b1;
                            frame_cnt_q <= '0;
                            state_q     <= BLANK;
                        end
                    end
                    BLANK: begin
                        if (vif.frame_start) begin
                            frame_cnt_q <= frame_inc_d;
                            if (frame_inc_d == FRAME_TARGET) begin
                                mode_q     <= next_q;
                                mode_req_q <= 1'b1;
                                state_q    <= REQ;
                            end
                        end
                    end
                    REQ: begin
                        if (vif.mode_ack) begin
                            mode_req_q <= 1'b0;
                            state_q    <= WAIT_VS2;
                        end
                    end
                    WAIT_VS2: begin
                        if (vif.frame_start) begin
                            blank_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= HOLD;
                endcase
            end
        end
    end

    assign vif.mode        = mode_q;
    assign vif.mode_req    = mode_req_q;
    assign vif.blank       = blank_q;
    assign vif.video_reset = video_reset_q;
    assign vif.busy        = busy_q;
endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed self-checking bench for video_mode_ctrl (DEBOUNCE_CYCLES=8, LOCK_CYCLES=32, BLANK_FRAMES=2).
module tb_video_mode_ctrl;
    logic clk;
    logic reset;
    logic pll_locked;
    logic key_mode;
    int   total;
    int   bad;

    video_mode_ctrl_if #(.MODE_W(2)) vif ();

`ifdef VIDEO_MODE_DIRECT_SEL_EN
    logic [1:0] mode_sel;
    logic       mode_sel_valid;
`endif

    video_mode_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .NUM_MODES(4),
        .MODE_W(2),
        .BLANK_FRAMES(2),
        .LOCK_CYCLES(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pll_locked(pll_locked),
        .key_mode(key_mode),
        .vif(vif.master)
`ifdef VIDEO_MODE_DIRECT_SEL_EN
        ,
        .mode_sel(mode_sel),
        .mode_sel_valid(mode_sel_valid)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fs();
        vif.frame_start = 1'b1;
        tick(1);
        vif.frame_start = 1'b0;
    endtask

    task automatic pulse_ack();
        vif.mode_ack = 1'b1;
        tick(1);
        vif.mode_ack = 1'b0;
    endtask

    // Press is accepted 10 cycles into the low phase; release settles within the high phase.
    task automatic press_key();
        key_mode = 1'b0;
        tick(12);
        key_mode = 1'b1;
        tick(12);
    endtask

    task automatic run_sequence();
        press_key();
        pulse_fs();
        pulse_fs();
        pulse_fs();
        tick(2);
        pulse_ack();
        pulse_fs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        if (vif.mode !== 2'd0) begin bad++; $display("FAIL rst_mode: got %0d want 0", vif.mode); end
        total++;
        if (vif.mode_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", vif.mode_req); end
        total++;
        if (vif.blank !== 1'b1) begin bad++; $display("FAIL rst_blank: got %b want 1", vif.blank); end
        total++;
        if (vif.video_reset !== 1'b1) begin bad++; $display("FAIL rst_vreset: got %b want 1", vif.video_reset); end
        total++;
        if (vif.busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", vif.busy); end
        total++;
        reset = 1'b0;
        tick(4);
        if (vif.video_reset !== 1'b1) begin bad++; $display("FAIL unlocked_vreset: got %b want 1", vif.video_reset); end
        total++;
    endtask

    task automatic test_lock();
        pll_locked = 1'b1;
        tick(33);
        if (vif.video_reset !== 1'b1) begin bad++; $display("FAIL lock_early: got %b want 1", vif.video_reset); end
        total++;
        tick(1);
        if (vif.video_reset !== 1'b0) begin bad++; $display("FAIL lock_release: got %b want 0", vif.video_reset); end
        total++;
        if (vif.blank !== 1'b0) begin bad++; $display("FAIL lock_blank: got %b want 0", vif.blank); end
        total++;
        if (vif.busy !== 1'b0) begin bad++; $display("FAIL lock_busy: got %b want 0", vif.busy); end
        total++;
        if (vif.mode !== 2'd0) begin bad++; $display("FAIL lock_mode: got %0d want 0", vif.mode); end
        total++;
    endtask

    task automatic test_debounce();
        key_mode = 1'b0;
        tick(5);
        key_mode = 1'b1;
        tick(15);
        if (vif.busy !== 1'b0) begin bad++; $display("FAIL bounce_busy: got %b want 0", vif.busy); end
        total++;
        if (vif.mode !== 2'd0) begin bad++; $display("FAIL bounce_mode: got %0d want 0", vif.mode); end
        total++;
        key_mode = 1'b0;
        tick(9);
        if (vif.busy !== 1'b0) begin bad++; $display("FAIL press_early: got %b want 0", vif.busy); end
        total++;
        tick(1);
        if (vif.busy !== 1'b1) begin bad++; $display("FAIL press_busy: got %b want 1", vif.busy); end
        total++;
        tick(10);
        key_mode = 1'b1;
        tick(12);
        if (vif.blank !== 1'b0) begin bad++; $display("FAIL wait_vs1_blank: got %b want 0", vif.blank); end
        total++;
        if (vif.mode !== 2'd0) begin bad++; $display("FAIL wait_vs1_mode: got %0d want 0", vif.mode); end
        total++;
    endtask

    task automatic test_full_sequence();
        pulse_fs();
        if (vif.blank !== 1'b1) begin bad++; $display("FAIL seq_blank_rise: got %b want 1", vif.blank); end
        total++;
        if (vif.mode !== 2'd0) begin bad++; $display("FAIL seq_mode_f1: got %0d want 0", vif.mode); end
        total++;
        pulse_fs();
        if (vif.mode_req !== 1'b0) begin bad++; $display("FAIL seq_req_f2: got %b want 0", vif.mode_req); end
        total++;
        if (vif.mode !== 2'd0) begin bad++; $display("FAIL seq_mode_f2: got %0d want 0", vif.mode); end
        total++;
        pulse_fs();
        if (vif.mode_req !== 1'b1) begin bad++; $display("FAIL seq_req_f3: got %b want 1", vif.mode_req); end
        total++;
        if (vif.mode !== 2'd1) begin bad++; $display("FAIL seq_mode_f3: got %0d want 1", vif.mode); end
        total++;
        tick(4);
        if (vif.mode_req !== 1'b1) begin bad++; $display("FAIL seq_req_hold: got %b want 1", vif.mode_req); end
        total++;
        pulse_ack();
        if (vif.mode_req !== 1'b0) begin bad++; $display("FAIL seq_req_drop: got %b want 0", vif.mode_req); end
        total++;
        if (vif.blank !== 1'b1) begin bad++; $display("FAIL seq_blank_vs2: got %b want 1", vif.blank); end
        total++;
        if (vif.busy !== 1'b1) begin bad++; $display("FAIL seq_busy_vs2: got %b want 1", vif.busy); end
        total++;
        pulse_fs();
        if (vif.blank !== 1'b0) begin bad++; $display("FAIL seq_unblank: got %b want 0", vif.blank); end
        total++;
        if (vif.busy !== 1'b0) begin bad++; $display("FAIL seq_done_busy: got %b want 0", vif.busy); end
        total++;
        if (vif.mode !== 2'd1) begin bad++; $display("FAIL seq_done_mode: got %0d want 1", vif.mode); end
        total++;
    endtask

    task automatic test_wrap();
        run_sequence();
        run_sequence();
        if (vif.mode !== 2'd3) begin bad++; $display("FAIL wrap_pre: got %0d want 3", vif.mode); end
        total++;
        run_sequence();
        if (vif.mode !== 2'd0) begin bad++; $display("FAIL wrap_mode: got %0d want 0", vif.mode); end
        total++;
        if (vif.busy !== 1'b0) begin bad++; $display("FAIL wrap_busy: got %b want 0", vif.busy); end
        total++;
    endtask

    task automatic test_press_during_blank();
        press_key();
        pulse_fs();
        press_key();
        if (vif.mode !== 2'd0) begin bad++; $display("FAIL pdb_mode_mid: got %0d want 0", vif.mode); end
        total++;
        pulse_fs();
        pulse_fs();
        if (vif.mode !== 2'd1) begin bad++; $display("FAIL pdb_mode_req: got %0d want 1", vif.mode); end
        total++;
        pulse_ack();
        pulse_fs();
        tick(10);
        if (vif.busy !== 1'b0) begin bad++; $display("FAIL pdb_busy: got %b want 0", vif.busy); end
        total++;
        if (vif.mode !== 2'd1) begin bad++; $display("FAIL pdb_mode_end: got %0d want 1", vif.mode); end
        total++;
    endtask

    task automatic test_pll_drop();
        press_key();
        pulse_fs();
        pulse_fs();
        pulse_fs();
        if (vif.mode_req !== 1'b1) begin bad++; $display("FAIL drop_in_req: got %b want 1", vif.mode_req); end
        total++;
        pll_locked = 1'b0;
        tick(2);
        if (vif.video_reset !== 1'b0) begin bad++; $display("FAIL drop_sync_lat: got %b want 0", vif.video_reset); end
        total++;
        tick(1);
        if (vif.video_reset !== 1'b1) begin bad++; $display("FAIL drop_vreset: got %b want 1", vif.video_reset); end
        total++;
        if (vif.mode_req !== 1'b0) begin bad++; $display("FAIL drop_req: got %b want 0", vif.mode_req); end
        total++;
        if (vif.blank !== 1'b1) begin bad++; $display("FAIL drop_blank: got %b want 1", vif.blank); end
        total++;
        if (vif.mode !== 2'd2) begin bad++; $display("FAIL drop_mode: got %0d want 2", vif.mode); end
        total++;
        pll_locked = 1'b1;
        tick(33);
        if (vif.video_reset !== 1'b1) begin bad++; $display("FAIL relock_early: got %b want 1", vif.video_reset); end
        total++;
        tick(1);
        if (vif.video_reset !== 1'b0) begin bad++; $display("FAIL relock_vreset: got %b want 0", vif.video_reset); end
        total++;
        if (vif.busy !== 1'b0) begin bad++; $display("FAIL relock_busy: got %b want 0", vif.busy); end
        total++;
        if (vif.mode !== 2'd2) begin bad++; $display("FAIL relock_mode: got %0d want 2", vif.mode); end
        total++;
        run_sequence();
        if (vif.mode !== 2'd3) begin bad++; $display("FAIL relock_next: got %0d want 3", vif.mode); end
        total++;
    endtask

    task automatic test_reset_mid_sequence();
        press_key();
        pulse_fs();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        if (vif.mode !== 2'd0) begin bad++; $display("FAIL mid_rst_mode: got %0d want 0", vif.mode); end
        total++;
        if (vif.video_reset !== 1'b1) begin bad++; $display("FAIL mid_rst_vreset: got %b want 1", vif.video_reset); end
        total++;
        if (vif.busy !== 1'b1) begin bad++; $display("FAIL mid_rst_busy: got %b want 1", vif.busy); end
        total++;
        tick(33);
        if (vif.video_reset !== 1'b1) begin bad++; $display("FAIL mid_rst_early: got %b want 1", vif.video_reset); end
        total++;
        tick(1);
        if (vif.video_reset !== 1'b0) begin bad++; $display("FAIL mid_rst_release: got %b want 0", vif.video_reset); end
        total++;
        if (vif.blank !== 1'b0) begin bad++; $display("FAIL mid_rst_blank: got %b want 0", vif.blank); end
        total++;
    endtask

`ifdef VIDEO_MODE_DIRECT_SEL_EN
    task automatic test_direct_sel();
        mode_sel       = 2'd2;
        mode_sel_valid = 1'b1;
        tick(1);
        mode_sel_valid = 1'b0;
        if (vif.busy !== 1'b1) begin bad++; $display("FAIL sel_busy: got %b want 1", vif.busy); end
        total++;
        pulse_fs();
        pulse_fs();
        pulse_fs();
        if (vif.mode !== 2'd2) begin bad++; $display("FAIL sel_mode_req: got %0d want 2", vif.mode); end
        total++;
        pulse_ack();
        pulse_fs();
        if (vif.busy !== 1'b0) begin bad++; $display("FAIL sel_done: got %b want 0", vif.busy); end
        total++;
        mode_sel_valid = 1'b1;
        tick(1);
        mode_sel_valid = 1'b0;
        if (vif.busy !== 1'b0) begin bad++; $display("FAIL sel_equal_ignored: got %b want 0", vif.busy); end
        total++;
    endtask
`endif

    initial begin
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        pll_locked       = 1'b0;
        key_mode         = 1'b1;
        vif.frame_start  = 1'b0;
        vif.mode_ack     = 1'b0;
`ifdef VIDEO_MODE_DIRECT_SEL_EN
        mode_sel         = 2'd0;
        mode_sel_valid   = 1'b0;
`endif
        test_reset();
        test_lock();
        test_debounce();
        test_full_sequence();
        test_wrap();
        test_press_during_blank();
        test_pll_drop();
        test_reset_mid_sequence();
`ifdef VIDEO_MODE_DIRECT_SEL_EN
        test_direct_sel();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
